// File: rtl/cpld_system_pkg.sv
// Shared definitions for the CPLD glue: bus widths, AVR command codes and bus FSM states.
package cpld_system_pkg;

   localparam int ADDR_W = 21;
   localparam int DATA_W = 8;
   localparam int CTRL_W = 9;

   localparam logic [6:0] CMD_IDLE     = 7'd1;
   localparam logic [6:0] CMD_RESET_LO = 7'd2;
   localparam logic [6:0] CMD_RESET_HI = 7'd3;
   localparam logic [6:0] CMD_SREG_LO  = 7'd4;
   localparam logic [6:0] CMD_SREG_HI  = 7'd5;
   localparam logic [6:0] CMD_SI_LO    = 7'd6;
   localparam logic [6:0] CMD_SI_HI    = 7'd7;
   localparam logic [6:0] CMD_OE_LO    = 7'd8;
   localparam logic [6:0] CMD_OE_HI    = 7'd9;
   localparam logic [6:0] CMD_WE_LO    = 7'd10;
   localparam logic [6:0] CMD_WE_HI    = 7'd12;
   localparam logic [6:0] CMD_CNT_LO   = 7'd13;
   localparam logic [6:0] CMD_CNT_HI   = 7'd14;
   localparam logic [6:0] CMD_SNES_LO  = 7'd15;
   localparam logic [6:0] CMD_SNES_HI  = 7'd16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_LATCH,
      ST_RD_OUT,
      ST_WR_LATCH,
      ST_WR_STROBE,
      ST_WR_HOLD
   } bus_state_t;

endpackage

// File: rtl/cpld_bus_fsm.sv
// Single-byte SRAM read/write sequencer run on behalf of the AVR; owns the data buffer
// and generates the SRAM strobes and the SRAM data drive enable.
module cpld_bus_fsm
   import cpld_system_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic              oe_n,
   input  logic              we_n,
   input  logic [DATA_W-1:0] avr_din,
   input  logic [DATA_W-1:0] sram_din,
   output logic [DATA_W-1:0] buffer,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_drive
);

   bus_state_t state, state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (clear) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Write data is taken as the cycle starts; read data on the last strobed clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buffer <= '0;
      end else if (!clear && state == ST_IDLE && state_next == ST_WR_LATCH) begin
         buffer <= avr_din;
      end else if (!clear && state == ST_RD_LATCH) begin
         buffer <= sram_din;
      end
   end

   always_comb begin
      state_next = state;
      sram_ce_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_drive = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && !we_n) begin
               state_next = ST_WR_LATCH;
            end else if (enable && !oe_n) begin
               state_next = ST_RD_ADDR;
            end
         end
         ST_RD_ADDR: begin
            sram_ce_n  = 1'b0;
            sram_oe_n  = 1'b0;
            state_next = ST_RD_LATCH;
         end
         ST_RD_LATCH: begin
            sram_ce_n  = 1'b0;
            sram_oe_n  = 1'b0;
            state_next = ST_RD_OUT;
         end
         ST_RD_OUT: begin
            state_next = ST_IDLE;
         end
         ST_WR_LATCH: begin
            state_next = ST_WR_STROBE;
         end
         ST_WR_STROBE: begin
            sram_ce_n  = 1'b0;
            sram_we_n  = 1'b0;
            sram_drive = 1'b1;
            state_next = ST_WR_HOLD;
         end
         ST_WR_HOLD: begin
            sram_ce_n  = 1'b0;
            sram_drive = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/cpld_system.sv
// CPLD glue top: command latches, serial/incrementing SRAM address register and bus FSM.
// Optional SNES pass-through mode is compiled in with `define CPLD_SNES_MODE_EN.
module cpld_system
   import cpld_system_pkg::*;
(
   input  logic              avr_clk,
   input  logic              avr_reset,
   input  logic              avr_sreg_en_n,
   input  logic              avr_si,
   input  logic              avr_counter_n,
   input  logic              avr_oe_n,
   input  logic              avr_we_n,
   input  logic [CTRL_W-1:0] avr_ctrl,
   inout  wire  [DATA_W-1:0] avr_data,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ce_n,
   input  logic [ADDR_W-1:0] snes_addr,
   inout  wire  [DATA_W-1:0] snes_data
);

   logic [6:0]        cmd;
   logic              rst_l, sreg_l, si_l, oe_l, we_l, cnt_l, snes_l;
   logic              sreg_eff, si_eff, oe_eff, we_eff, cnt_eff;
   logic              cnt_q, cnt_fall;
   logic              snes_active;
   logic              unused_bits;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] buffer;
   logic              fsm_ce_n, fsm_oe_n, fsm_we_n, fsm_drive;
   logic              avr_drive;

   assign cmd = avr_ctrl[6:0];

   // Command latches let the AVR override every control pin through avr_ctrl.
   always_ff @(posedge avr_clk or negedge avr_reset) begin
      if (!avr_reset) begin
         rst_l  <= 1'b0;
         sreg_l <= 1'b1;
         si_l   <= 1'b0;
         oe_l   <= 1'b1;
         we_l   <= 1'b1;
         cnt_l  <= 1'b1;
         snes_l <= 1'b0;
      end else begin
         case (cmd)
            CMD_RESET_LO: rst_l  <= 1'b0;
            CMD_RESET_HI: rst_l  <= 1'b1;
            CMD_SREG_LO:  sreg_l <= 1'b0;
            CMD_SREG_HI:  sreg_l <= 1'b1;
            CMD_SI_LO:    si_l   <= 1'b0;
            CMD_SI_HI:    si_l   <= 1'b1;
            CMD_OE_LO:    oe_l   <= 1'b0;
            CMD_OE_HI:    oe_l   <= 1'b1;
            CMD_WE_LO:    we_l   <= 1'b0;
            CMD_WE_HI:    we_l   <= 1'b1;
            CMD_CNT_LO:   cnt_l  <= 1'b0;
            CMD_CNT_HI:   cnt_l  <= 1'b1;
            CMD_SNES_LO:  snes_l <= 1'b0;
            CMD_SNES_HI:  snes_l <= 1'b1;
            default: ;
         endcase
      end
   end

   assign sreg_eff = avr_sreg_en_n & sreg_l;
   assign si_eff   = avr_si | si_l;
   assign oe_eff   = avr_oe_n & oe_l;
   assign we_eff   = avr_we_n & we_l;
   assign cnt_eff  = avr_counter_n & cnt_l;
   assign cnt_fall = cnt_q & ~cnt_eff;

   // Shift loads MSB first and takes priority over a counter falling edge.
   always_ff @(posedge avr_clk or negedge avr_reset) begin
      if (!avr_reset) begin
         addr  <= '0;
         cnt_q <= 1'b1;
      end else begin
         cnt_q <= cnt_eff;
         if (rst_l) begin
            addr <= '0;
         end else if (!sreg_eff) begin
            addr <= {addr[ADDR_W-2:0], si_eff};
         end else if (cnt_fall) begin
            addr <= addr + ADDR_W'(1);
         end
      end
   end

   cpld_bus_fsm u_bus_fsm (
      .clk        (avr_clk),
      .rst_n      (avr_reset),
      .clear      (rst_l | snes_active),
      .enable     (sreg_eff),
      .oe_n       (oe_eff),
      .we_n       (we_eff),
      .avr_din    (avr_data),
      .sram_din   (sram_data),
      .buffer     (buffer),
      .sram_ce_n  (fsm_ce_n),
      .sram_oe_n  (fsm_oe_n),
      .sram_we_n  (fsm_we_n),
      .sram_drive (fsm_drive)
   );

`ifdef CPLD_SNES_MODE_EN
   assign snes_active = snes_l;
   assign sram_addr   = snes_active ? snes_addr : addr;
   assign sram_ce_n   = snes_active ? 1'b0 : fsm_ce_n;
   assign sram_oe_n   = snes_active ? 1'b0 : fsm_oe_n;
   assign snes_data   = snes_active ? sram_data : {DATA_W{1'bz}};
   assign unused_bits = ^avr_ctrl[CTRL_W-1:7];
`else
   assign snes_active = 1'b0;
   assign sram_addr   = addr;
   assign sram_ce_n   = fsm_ce_n;
   assign sram_oe_n   = fsm_oe_n;
   assign snes_data   = {DATA_W{1'bz}};
   assign unused_bits = ^{avr_ctrl[CTRL_W-1:7], snes_addr, snes_l};
`endif

   assign sram_we_n = fsm_we_n;

   // Gating with reset releases the AVR bus the moment reset asserts.
   assign avr_drive = avr_reset & ~oe_eff & we_eff & ~snes_active;
   assign avr_data  = avr_drive ? buffer : {DATA_W{1'bz}};
   assign sram_data = fsm_drive ? buffer : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cpld_system.sv
// Self-checking bench for cpld_system: address shift/count, soft reset, SRAM read/write
// cycles through a scoreboard, and the SNES mode behaviour for the current build.
module tb_cpld_system;

   typedef struct {
      logic       is_write;
      logic [7:0] data;
   } vec_t;

   logic        avr_clk;
   logic        avr_reset;
   logic        avr_sreg_en_n;
   logic        avr_si;
   logic        avr_counter_n;
   logic        avr_oe_n;
   logic        avr_we_n;
   logic [8:0]  avr_ctrl;
   wire  [7:0]  avr_data;
   wire  [7:0]  sram_data;
   logic [20:0] sram_addr;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic        sram_ce_n;
   logic [20:0] snes_addr;
   wire  [7:0]  snes_data;

   logic        tb_avr_en;
   logic [7:0]  tb_avr_val;
   logic        tb_sram_en;
   logic [7:0]  tb_sram_val;

   int          checks;
   int          errors;
   int          rd_done;
   int          wr_done;
   int          we_low_cnt;
   logic        prev_oe_n;
   logic [7:0]  rd_q[$];
   logic [7:0]  wr_q[$];
   vec_t        vecs[7];

   assign avr_data  = tb_avr_en  ? tb_avr_val  : 8'bz;
   assign sram_data = tb_sram_en ? tb_sram_val : 8'bz;

   cpld_system dut (
      .avr_clk       (avr_clk),
      .avr_reset     (avr_reset),
      .avr_sreg_en_n (avr_sreg_en_n),
      .avr_si        (avr_si),
      .avr_counter_n (avr_counter_n),
      .avr_oe_n      (avr_oe_n),
      .avr_we_n      (avr_we_n),
      .avr_ctrl      (avr_ctrl),
      .avr_data      (avr_data),
      .sram_data     (sram_data),
      .sram_addr     (sram_addr),
      .sram_oe_n     (sram_oe_n),
      .sram_we_n     (sram_we_n),
      .sram_ce_n     (sram_ce_n),
      .snes_addr     (snes_addr),
      .snes_data     (snes_data)
   );

   initial avr_clk = 1'b0;
   always #5 avr_clk = ~avr_clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboard side: pops an expected byte whenever the DUT completes a read or strobes a write.
   initial prev_oe_n = 1'b1;
   always @(negedge avr_clk) begin
      if (sram_we_n == 1'b0) begin
         we_low_cnt++;
         if (wr_q.size() > 0) begin
            logic [7:0] exp_w;
            exp_w = wr_q.pop_front();
            checkOutput("wr_data", {24'd0, sram_data}, {24'd0, exp_w});
            checkOutput("wr_ce_n", {31'd0, sram_ce_n}, 32'd0);
            wr_done++;
         end
      end
      if (prev_oe_n == 1'b0 && sram_oe_n == 1'b1 && rd_q.size() > 0) begin
         logic [7:0] exp_r;
         exp_r = rd_q.pop_front();
         checkOutput("rd_data", {24'd0, avr_data}, {24'd0, exp_r});
         rd_done++;
      end
      prev_oe_n = sram_oe_n;
   end

   task automatic shiftAddress(input logic [20:0] value);
      for (int i = 20; i >= 0; i--) begin
         @(negedge avr_clk);
         avr_sreg_en_n = 1'b0;
         avr_si        = value[i];
      end
      @(negedge avr_clk);
      avr_sreg_en_n = 1'b1;
      avr_si        = 1'b0;
   endtask

   task automatic pulseCounter();
      @(negedge avr_clk);
      avr_counter_n = 1'b0;
      repeat (2) @(negedge avr_clk);
      avr_counter_n = 1'b1;
      repeat (2) @(negedge avr_clk);
   endtask

   task automatic sendCmd(input logic [8:0] code);
      @(negedge avr_clk);
      avr_ctrl = code;
   endtask

   task automatic applyStimulus(input vec_t v);
      int start;
      int base;
      bit done;
      done = 1'b0;
      if (v.is_write) begin
         tb_avr_val = v.data;
         tb_avr_en  = 1'b1;
         wr_q.push_back(v.data);
         start = wr_done;
         base  = we_low_cnt;
         @(negedge avr_clk);
         avr_we_n = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge avr_clk);
            #1;
            if (wr_done != start) begin
               done = 1'b1;
               break;
            end
         end
         avr_we_n  = 1'b1;
         tb_avr_en = 1'b0;
         repeat (4) @(negedge avr_clk);
         checkOutput("wr_complete", {31'd0, done}, 32'd1);
         checkOutput("wr_we_width", we_low_cnt - base, 32'd1);
      end else begin
         tb_sram_val = v.data;
         tb_sram_en  = 1'b1;
         rd_q.push_back(v.data);
         start = rd_done;
         @(negedge avr_clk);
         avr_oe_n = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge avr_clk);
            #1;
            if (rd_done != start) begin
               done = 1'b1;
               break;
            end
         end
         avr_oe_n = 1'b1;
         repeat (3) @(negedge avr_clk);
         tb_sram_en = 1'b0;
         checkOutput("rd_complete", {31'd0, done}, 32'd1);
      end
   endtask

   initial begin
      int n;
      checks        = 0;
      errors        = 0;
      rd_done       = 0;
      wr_done       = 0;
      we_low_cnt    = 0;
      avr_reset     = 1'b0;
      avr_sreg_en_n = 1'b1;
      avr_si        = 1'b0;
      avr_counter_n = 1'b1;
      avr_oe_n      = 1'b1;
      avr_we_n      = 1'b1;
      avr_ctrl      = 9'd1;
      snes_addr     = 21'h123456 & 21'h1FFFFF;
      tb_avr_en     = 1'b0;
      tb_avr_val    = 8'h00;
      tb_sram_en    = 1'b0;
      tb_sram_val   = 8'h00;

      vecs[0] = '{1'b0, 8'h3C};
      vecs[1] = '{1'b1, 8'hEE};
      vecs[2] = '{1'b0, 8'h00};
      vecs[3] = '{1'b1, 8'hFF};
      vecs[4] = '{1'b0, 8'hFF};
      vecs[5] = '{1'b1, 8'h01};
      vecs[6] = '{1'b0, 8'h5A};

      repeat (3) @(negedge avr_clk);
      checkOutput("rst_addr", {11'd0, sram_addr}, 32'd0);
      checkOutput("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
      checkOutput("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      checkOutput("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      avr_reset = 1'b1;
      repeat (2) @(negedge avr_clk);

      shiftAddress(21'h04CCF);
      checkOutput("shift_addr", {11'd0, sram_addr}, 32'h04CCF);
      pulseCounter();
      checkOutput("count_inc", {11'd0, sram_addr}, 32'h04CD0);
      shiftAddress(21'h1FFFFF);
      checkOutput("shift_max", {11'd0, sram_addr}, 32'h1FFFFF);
      pulseCounter();
      checkOutput("count_wrap", {11'd0, sram_addr}, 32'h0);

      // Read latency and repeated reads while oe_n stays low.
      tb_sram_val = 8'hAA;
      tb_sram_en  = 1'b1;
      @(negedge avr_clk);
      avr_oe_n = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge avr_clk);
         n++;
         if (avr_data == 8'hAA) break;
      end
      checkOutput("rd_latency", n, 32'd3);
      tb_sram_val = 8'hBB;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge avr_clk);
         n++;
         if (avr_data == 8'hBB) break;
      end
      checkOutput("rd_repeat", n, 32'd4);
      avr_oe_n = 1'b1;
      repeat (4) @(negedge avr_clk);
      tb_sram_en = 1'b0;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      // Soft reset then command-driven shifting.
      pulseCounter();
      checkOutput("pre_soft", {11'd0, sram_addr}, 32'd1);
      sendCmd(9'd3);
      sendCmd(9'd2);
      sendCmd(9'd1);
      checkOutput("soft_rst_addr", {11'd0, sram_addr}, 32'd0);
      sendCmd(9'd4);
      sendCmd(9'd7);
      sendCmd(9'd6);
      sendCmd(9'd1);
      @(negedge avr_clk);
      checkOutput("cmd_shift_a", {11'd0, sram_addr}, 32'd2);
      avr_ctrl = 9'd5;
      sendCmd(9'd1);
      @(negedge avr_clk);
      checkOutput("cmd_shift_b", {11'd0, sram_addr}, 32'd4);

      tb_sram_val = 8'h5A;
      tb_sram_en  = 1'b1;
      sendCmd(9'd16);
      sendCmd(9'd1);
      @(negedge avr_clk);
`ifdef CPLD_SNES_MODE_EN
      checkOutput("snes_addr", {11'd0, sram_addr}, 32'h123456);
      checkOutput("snes_data", {24'd0, snes_data}, 32'h5A);
      checkOutput("snes_ce_n", {31'd0, sram_ce_n}, 32'd0);
      checkOutput("snes_oe_n", {31'd0, sram_oe_n}, 32'd0);
`else
      checkOutput("snes_off_addr", {11'd0, sram_addr}, 32'd4);
      checkOutput("snes_off_ce_n", {31'd0, sram_ce_n}, 32'd1);
`endif
      sendCmd(9'd15);
      sendCmd(9'd1);
      repeat (2) @(negedge avr_clk);

      // Asynchronous reset in the middle of a read cycle.
      tb_sram_val = 8'h11;
      @(negedge avr_clk);
      avr_oe_n = 1'b0;
      repeat (2) @(negedge avr_clk);
      #1;
      checkOutput("mid_rd_oe_n", {31'd0, sram_oe_n}, 32'd0);
      avr_reset = 1'b0;
      #1;
      checkOutput("async_oe_n", {31'd0, sram_oe_n}, 32'd1);
      checkOutput("async_ce_n", {31'd0, sram_ce_n}, 32'd1);
      checkOutput("async_addr", {11'd0, sram_addr}, 32'd0);
      avr_oe_n = 1'b1;
      @(negedge avr_clk);
      avr_reset  = 1'b1;
      tb_sram_en = 1'b0;
      repeat (2) @(negedge avr_clk);

      checkOutput("rd_q_empty", rd_q.size(), 32'd0);
      checkOutput("wr_q_empty", wr_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
